// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one registered-read block-RAM port among NUM_CLIENTS requesters.
// Define RAM_CLEAR_EN to zero-fill the whole RAM after reset, before any request is accepted.
module ram_port_arbiter #(
   parameter int NUM_CLIENTS = 4,
   parameter int WORD_WIDTH  = 16,
   parameter int ADDR_WIDTH  = 9
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_CLIENTS-1:0]            req,
   input  logic [NUM_CLIENTS-1:0]            wr,
   input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] addr,
   input  logic [NUM_CLIENTS*WORD_WIDTH-1:0] wdata,
   output logic [NUM_CLIENTS-1:0]            gnt,
   output logic [NUM_CLIENTS-1:0]            rvalid,
   output logic [WORD_WIDTH-1:0]             rdata,
   output logic                              busy,
   output logic [ADDR_WIDTH-1:0]             ram_addr,
   output logic [WORD_WIDTH-1:0]             ram_data,
   output logic                              ram_wren,
   input  logic [WORD_WIDTH-1:0]             ram_q
);

   localparam int               IDX_W    = $clog2(NUM_CLIENTS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLIENTS - 1);
   localparam logic [IDX_W:0]   NC_WIDE  = (IDX_W + 1)'(NUM_CLIENTS);

   logic [IDX_W-1:0]      r_ptr;
   logic                  r_tag1_vld;
   logic                  r_tag2_vld;
   logic [IDX_W-1:0]      r_tag1_idx;
   logic [IDX_W-1:0]      r_tag2_idx;

   logic [IDX_W:0]        w_sum;
   logic [IDX_W-1:0]      w_cand;
   logic                  w_found;
   logic [IDX_W-1:0]      w_win_idx;
   logic                  w_win_wr;
   logic [ADDR_WIDTH-1:0] w_win_addr;
   logic [WORD_WIDTH-1:0] w_win_data;
   logic                  w_xfer;
   logic                  w_clr_wr;
   logic [ADDR_WIDTH-1:0] w_clr_addr;

   // Search from the client after the last winner, wrapping once around.
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_sum      = '0;
      w_cand     = '0;
      w_found    = 1'b0;
      w_win_idx  = '0;
      w_win_wr   = 1'b0;
      w_win_addr = '0;
      w_win_data = '0;
      for (int i = 1; i <= NUM_CLIENTS; i++) begin
         w_sum = {1'b0, r_ptr} + (IDX_W + 1)'(i);
         if (w_sum >= NC_WIDE) begin
            w_sum = w_sum - NC_WIDE;
         end
         w_cand = w_sum[IDX_W-1:0];
         if (!w_found && req[w_cand]) begin
            w_found    = 1'b1;
            w_win_idx  = w_cand;
            w_win_wr   = wr[w_cand];
            w_win_addr = addr[w_cand*ADDR_WIDTH +: ADDR_WIDTH];
            w_win_data = wdata[w_cand*WORD_WIDTH +: WORD_WIDTH];
         end
      end
   end

   always_comb begin
      gnt = '0;
      if (w_found && !busy && !rst) begin
         gnt[w_win_idx] = 1'b1;
      end
   end

   assign w_xfer = |gnt;

   // The read tag travels two stages so it lines up with the RAM's registered output.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr      <= LAST_IDX;
         r_tag1_vld <= 1'b0;
         r_tag1_idx <= '0;
         r_tag2_vld <= 1'b0;
         r_tag2_idx <= '0;
      end else begin
         if (w_xfer) begin
            r_ptr <= w_win_idx;
         end
         r_tag1_vld <= w_xfer & ~w_win_wr;
         r_tag1_idx <= w_win_idx;
         r_tag2_vld <= r_tag1_vld;
         r_tag2_idx <= r_tag1_idx;
      end
   end

   // Address and data hold between transfers; only the write enable drops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ram_addr <= '0;
         ram_data <= '0;
         ram_wren <= 1'b0;
      end else if (w_clr_wr) begin
         ram_addr <= w_clr_addr;
         ram_data <= '0;
         ram_wren <= 1'b1;
      end else if (w_xfer) begin
         ram_addr <= w_win_addr;
         ram_data <= w_win_data;
         ram_wren <= w_win_wr;
      end else begin
         ram_wren <= 1'b0;
      end
   end

   always_comb begin
      rvalid = '0;
      if (r_tag2_vld) begin
         rvalid[r_tag2_idx] = 1'b1;
      end
   end

   assign rdata = ram_q;

`ifdef RAM_CLEAR_EN
   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_RUN   = 1'b1;

   logic [0:0]            r_state;
   logic [ADDR_WIDTH-1:0] r_clr_addr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_CLEAR;
         r_clr_addr <= '0;
      end else if (r_state == ST_CLEAR) begin
         r_clr_addr <= r_clr_addr + 1'b1;
         if (r_clr_addr == '1) begin
            r_state <= ST_RUN;
         end
      end
   end

   assign busy       = (r_state == ST_CLEAR);
   assign w_clr_wr   = busy;
   assign w_clr_addr = r_clr_addr;
`else
   assign busy       = 1'b0;
   assign w_clr_wr   = 1'b0;
   assign w_clr_addr = '0;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: a behavioural RAM plus a transaction-level
// reference model (shadow memory, round-robin search, due-cycle read queue).
module tb_ram_port_arbiter;

   localparam int NC    = 4;
   localparam int AW    = 9;
   localparam int WW    = 16;
   localparam int DEPTH = 1 << AW;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NC-1:0]     req;
   logic [NC-1:0]     wr;
   logic [NC*AW-1:0]  addr;
   logic [NC*WW-1:0]  wdata;
   logic [NC-1:0]     gnt;
   logic [NC-1:0]     rvalid;
   logic [WW-1:0]     rdata;
   logic              busy;
   logic [AW-1:0]     ram_addr;
   logic [WW-1:0]     ram_data;
   logic              ram_wren;
   logic [WW-1:0]     ram_q;

   ram_port_arbiter #(
      .NUM_CLIENTS(NC),
      .WORD_WIDTH (WW),
      .ADDR_WIDTH (AW)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .wr      (wr),
      .addr    (addr),
      .wdata   (wdata),
      .gnt     (gnt),
      .rvalid  (rvalid),
      .rdata   (rdata),
      .busy    (busy),
      .ram_addr(ram_addr),
      .ram_data(ram_data),
      .ram_wren(ram_wren),
      .ram_q   (ram_q)
   );

   always #5 clk = ~clk;

   function automatic logic [WW-1:0] init_val(input int i);
      return WW'(i * 2654 + 23130);
   endfunction

   // Block RAM port: synchronous write, registered read.
   logic [WW-1:0] ram_mem [DEPTH];
   initial begin
      for (int i = 0; i < DEPTH; i++) ram_mem[i] = init_val(i);
      forever begin
         @(posedge clk);
         if (ram_wren) ram_mem[ram_addr] <= ram_data;
         ram_q <= ram_mem[ram_addr];
      end
   end

   typedef struct {
      int          due;
      int          idx;
      logic [WW-1:0] data;
   } rd_t;

   int            checks   = 0;
   int            failures = 0;
   logic [NC-1:0] cl_req   = '0;
   logic [NC-1:0] cl_wr    = '0;
   logic [AW-1:0] cl_addr [NC];
   logic [WW-1:0] cl_data [NC];
   int            wait_cnt [NC];
   logic [WW-1:0] shadow [DEPTH];
   int            ref_ptr  = NC - 1;
   int            cyc      = 0;
   int            last_w;
   logic [NC-1:0] last_gnt;
   rd_t           pend [$];

   task automatic drive();
      req = cl_req;
      wr  = cl_wr;
      for (int k = 0; k < NC; k++) begin
         addr[k*AW +: AW]  = cl_addr[k];
         wdata[k*WW +: WW] = cl_data[k];
      end
   endtask

   task automatic arm(input int k, input logic w, input logic [AW-1:0] a, input logic [WW-1:0] d);
      cl_req[k]   = 1'b1;
      cl_wr[k]    = w;
      cl_addr[k]  = a;
      cl_data[k]  = d;
      wait_cnt[k] = 0;
   endtask

   // One clock of traffic, starting and ending on a falling edge, scored against the model.
   task automatic step();
      int            w;
      int            c;
      logic [NC-1:0] eg;
      logic [NC-1:0] erv;
      logic [WW-1:0] erd;
      rd_t           e;
      drive();
      #1;
      w = -1;
      for (int i = 1; i <= NC; i++) begin
         c = (ref_ptr + i) % NC;
         if (w < 0 && cl_req[c]) w = c;
      end
      eg = '0;
      if (w >= 0) eg[w] = 1'b1;
      last_gnt = gnt;
      last_w   = w;
      checks++;
      if (gnt !== eg) begin
         failures++;
         $display("FAIL grant cyc=%0d got=%b exp=%b", cyc, gnt, eg);
      end
      if (w >= 0) begin
         for (int k = 0; k < NC; k++) begin
            if (k != w && cl_req[k]) begin
               wait_cnt[k]++;
               checks++;
               if (wait_cnt[k] > NC - 1) begin
                  failures++;
                  $display("FAIL fairness client=%0d waited=%0d max=%0d", k, wait_cnt[k], NC - 1);
               end
            end
         end
         if (cl_wr[w]) shadow[cl_addr[w]] = cl_data[w];
         else pend.push_back('{due: cyc + 2, idx: w, data: shadow[cl_addr[w]]});
         ref_ptr = w;
      end
      @(posedge clk);
      cyc++;
      if (w >= 0) cl_req[w] = 1'b0;
      #1;
      erv = '0;
      erd = '0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
         e = pend.pop_front();
         erv[e.idx] = 1'b1;
         erd = e.data;
      end
      checks++;
      if (rvalid !== erv) begin
         failures++;
         $display("FAIL rvalid cyc=%0d got=%b exp=%b", cyc, rvalid, erv);
      end
      if (erv != '0) begin
         checks++;
         if (rdata !== erd) begin
            failures++;
            $display("FAIL rdata cyc=%0d got=%h exp=%h", cyc, rdata, erd);
         end
      end
      @(negedge clk);
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL busy_release got=%b exp=0", busy);
      end
`ifdef RAM_CLEAR_EN
      for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
`endif
   endtask

   task automatic assert_rst();
      rst = 1'b1;
      pend.delete();
      ref_ptr = NC - 1;
   endtask

   task automatic do_reset();
      cl_req = '0;
      for (int i = 0; i < 3; i++) step();
      assert_rst();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      wait_ready();
   endtask

   task automatic test_reset();
      logic exp_busy;
`ifdef RAM_CLEAR_EN
      exp_busy = 1'b1;
`else
      exp_busy = 1'b0;
`endif
      cl_req = '1;
      cl_wr  = '0;
      drive();
      #12;
      checks++;
      if (gnt !== '0) begin failures++; $display("FAIL reset_gnt got=%b exp=0", gnt); end
      checks++;
      if (rvalid !== '0) begin failures++; $display("FAIL reset_rvalid got=%b exp=0", rvalid); end
      checks++;
      if (ram_wren !== 1'b0 || ram_addr !== '0 || ram_data !== '0) begin
         failures++;
         $display("FAIL reset_ram got wren=%b addr=%h data=%h exp all 0", ram_wren, ram_addr, ram_data);
      end
      checks++;
      if (busy !== exp_busy) begin failures++; $display("FAIL reset_busy got=%b exp=%b", busy, exp_busy); end
      cl_req = '0;
      drive();
      @(negedge clk);
      rst = 1'b0;
      wait_ready();
   endtask

   task automatic test_write_read();
      arm(1, 1'b1, 9'd5, 16'h1234);
      step();
      checks++;
      if (last_gnt !== 4'b0010) begin failures++; $display("FAIL wr_gnt got=%b exp=0010", last_gnt); end
      arm(1, 1'b0, 9'd5, 16'h0000);
      step();
      checks++;
      if (last_gnt !== 4'b0010) begin failures++; $display("FAIL rd_gnt got=%b exp=0010", last_gnt); end
      step();
      checks++;
      if (rvalid !== 4'b0010 || rdata !== 16'h1234) begin
         failures++;
         $display("FAIL wr_rd_data got rvalid=%b rdata=%h exp 0010/1234", rvalid, rdata);
      end
      step();
   endtask

   task automatic test_round_robin();
      int seq [6];
      seq = '{0, 1, 2, 3, 0, 1};
      do_reset();
      for (int k = 0; k < NC; k++) arm(k, 1'b0, AW'($urandom_range(0, DEPTH - 1)), '0);
      for (int i = 0; i < 6; i++) begin
         step();
         checks++;
         if (last_w !== seq[i]) begin
            failures++;
            $display("FAIL rr_order step=%0d got=%0d exp=%0d", i, last_w, seq[i]);
         end
         arm(last_w, 1'b0, AW'($urandom_range(0, DEPTH - 1)), '0);
      end
      cl_req = '0;
      for (int i = 0; i < 3; i++) step();
   endtask

   task automatic test_priority();
      int seq [3];
      seq = '{3, 0, 2};
      for (int i = 0; i < 3; i++) begin
         arm(2, 1'b0, AW'($urandom_range(0, 7)), '0);
         step();
         checks++;
         if (last_w !== 2) begin failures++; $display("FAIL solo_grant got=%0d exp=2", last_w); end
      end
      arm(0, 1'b1, 9'd3, 16'hA5A5);
      arm(3, 1'b0, 9'd3, '0);
      arm(2, 1'b0, 9'd3, '0);
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (last_w !== seq[i]) begin
            failures++;
            $display("FAIL join_order step=%0d got=%0d exp=%0d", i, last_w, seq[i]);
         end
      end
      for (int i = 0; i < 3; i++) step();
   endtask

   task automatic test_wrap();
      arm(0, 1'b1, 9'h1FF, 16'hBEEF);
      step();
      arm(3, 1'b0, 9'h1FF, '0);
      step();
      step();
      checks++;
      if (rvalid !== 4'b1000 || rdata !== 16'hBEEF) begin
         failures++;
         $display("FAIL top_addr got rvalid=%b rdata=%h exp 1000/beef", rvalid, rdata);
      end
      step();
   endtask

   task automatic test_reset_midflight();
      int bad;
      arm(2, 1'b0, 9'd10, '0);
      step();
      assert_rst();
      cl_req = '1;
      cl_wr  = '0;
      drive();
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         if (rvalid !== '0 || gnt !== '0) bad++;
         @(negedge clk);
      end
      checks++;
      if (bad != 0) begin failures++; $display("FAIL midrst_quiet got=%0d bad cycles exp=0", bad); end
      cl_req = '0;
      drive();
      rst = 1'b0;
      wait_ready();
      for (int i = 0; i < 4; i++) step();
      for (int k = 0; k < NC; k++) arm(k, 1'b0, AW'(k), '0);
      drive();
      #1;
      checks++;
      if (gnt !== 4'b0001) begin failures++; $display("FAIL ptr_restart got=%b exp=0001", gnt); end
      for (int i = 0; i < NC + 3; i++) step();
   endtask

   task automatic test_random();
      logic [AW-1:0] a;
      for (int n = 0; n < 400; n++) begin
         for (int k = 0; k < NC; k++) begin
            if (!cl_req[k] && $urandom_range(0, 1) == 1) begin
               a = ($urandom_range(0, 4) == 0) ? 9'h1FF : AW'($urandom_range(0, 7));
               arm(k, 1'($urandom_range(0, 1)), a, WW'($urandom));
            end
         end
         step();
      end
      cl_req = '0;
      for (int i = 0; i < 3; i++) step();
   endtask

`ifdef RAM_CLEAR_EN
   task automatic count_clear(input int abort_at, output int n, output int gnt_bad);
      n       = 0;
      gnt_bad = 0;
      #1;
      while (busy === 1'b1 && n < 2000 && n != abort_at) begin
         if (gnt !== '0) gnt_bad++;
         n++;
         @(negedge clk);
         #1;
      end
   endtask

   task automatic test_clear();
      int n;
      int bad;
      cl_req = '0;
      for (int i = 0; i < 3; i++) step();
      assert_rst();
      @(negedge clk);
      for (int k = 0; k < NC; k++) arm(k, 1'b0, AW'($urandom_range(0, DEPTH - 1)), '0);
      drive();
      rst = 1'b0;
      count_clear(100, n, bad);
      checks++;
      if (n != 100) begin failures++; $display("FAIL clear_early_end got=%0d exp=100", n); end
      assert_rst();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      count_clear(-1, n, bad);
      checks++;
      if (n != DEPTH) begin failures++; $display("FAIL clear_len got=%0d exp=%0d", n, DEPTH); end
      checks++;
      if (bad != 0) begin failures++; $display("FAIL clear_gnt got=%0d grants exp=0", bad); end
      for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
      for (int i = 0; i < 60; i++) begin
         if (i < 40) arm(i % NC, 1'b0, AW'($urandom_range(0, DEPTH - 1)), '0);
         step();
      end
   endtask
`endif

   initial begin
      for (int i = 0; i < DEPTH; i++) shadow[i] = init_val(i);
      for (int k = 0; k < NC; k++) begin
         cl_addr[k]  = '0;
         cl_data[k]  = '0;
         wait_cnt[k] = 0;
      end
      drive();
      test_reset();
      test_write_read();
      test_round_robin();
      test_priority();
      test_wrap();
      test_reset_midflight();
      test_random();
`ifdef RAM_CLEAR_EN
      test_clear();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
